// File: rtl/ws2812b_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// Module : ws2812b_frame_serializer_if
// Brief  : valid/ready stream carrying 24-bit GRB pixel words
// Rev    : 1.0
// ============================================================================
interface ws2812b_frame_serializer_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (output pixel_data, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_data, input pixel_valid, output pixel_ready);
endinterface
`default_nettype wire

// File: rtl/ws2812b_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module : ws2812b_frame_serializer
// Brief  : splits GRB pixel words into MSB-first bits with one trigger per bit
// Rev    : 1.0
// ============================================================================
module ws2812b_frame_serializer #(
  parameter int LED_COUNT                 = 8,
  parameter int BIT_DURATION_CLK_COUNTS   = 62,
  parameter int RESET_DURATION_CLK_COUNTS = 2500
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  ws2812b_frame_serializer_if.slave          pix,
  output logic                               trigger,
  output logic                               bit_to_code,
  output logic                               busy,
  output logic [$clog2(LED_COUNT+1)-1:0]     pixel_index,
  output logic                               frame_done,
  output logic                               underrun
);

  localparam int c_idx_w = $clog2(LED_COUNT + 1);
  localparam int c_clk_w = (BIT_DURATION_CLK_COUNTS > 1) ? $clog2(BIT_DURATION_CLK_COUNTS) : 1;
  localparam int c_gap_w = (RESET_DURATION_CLK_COUNTS > 1) ? $clog2(RESET_DURATION_CLK_COUNTS) : 1;

  localparam logic [c_idx_w-1:0] c_led_count = c_idx_w'(LED_COUNT);
  localparam logic [c_clk_w-1:0] c_bit_last  = c_clk_w'(BIT_DURATION_CLK_COUNTS - 1);
  localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(RESET_DURATION_CLK_COUNTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FIRST_FETCH = 2'd1,
    ST_SEND        = 2'd2,
    ST_LATCH       = 2'd3
  } state_t;

  state_t               r_state;
  logic [23:0]          r_shift;
  logic [23:0]          r_shadow;
  logic                 r_shadow_full;
  logic [c_idx_w-1:0]   r_pixel_index;
  logic [4:0]           r_bit_cnt;
  logic [c_clk_w-1:0]   r_clk_cnt;
  logic [c_gap_w-1:0]   r_gap_cnt;
  logic                 r_trigger;
  logic                 r_bit;
  logic                 r_frame_done;
  logic                 r_underrun;
  logic                 r_aborted;

  logic w_ready;
  logic w_fire;
  logic w_bit_end;

  // While the shadow is full ready stays low, so a fill never meets a drain.
  assign w_ready   = (r_state == ST_FIRST_FETCH) ||
                     ((r_state == ST_SEND) && !r_shadow_full && (r_pixel_index < c_led_count));
  assign w_fire    = pix.pixel_valid && w_ready;
  assign w_bit_end = (r_clk_cnt == c_bit_last);

  assign pix.pixel_ready = w_ready;
  assign trigger         = r_trigger;
  assign bit_to_code     = r_bit;
  assign busy            = (r_state != ST_IDLE);
  assign pixel_index     = r_pixel_index;
  assign frame_done      = r_frame_done;
  assign underrun        = r_underrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_pixel_index <= '0;
      r_bit_cnt     <= '0;
      r_clk_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_trigger     <= 1'b0;
      r_bit         <= 1'b0;
      r_frame_done  <= 1'b0;
      r_underrun    <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_trigger    <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;

      if (w_fire && (r_state == ST_SEND)) begin
        r_shadow      <= pix.pixel_data;
        r_shadow_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_FIRST_FETCH;
            r_pixel_index <= '0;
            r_shadow_full <= 1'b0;
            r_aborted     <= 1'b0;
          end
        end

        ST_FIRST_FETCH: begin
          if (w_fire) begin
            r_shift       <= pix.pixel_data;
            r_bit         <= pix.pixel_data[23];
            r_trigger     <= 1'b1;
            r_pixel_index <= c_idx_w'(1);
            r_bit_cnt     <= '0;
            r_clk_cnt     <= '0;
            r_state       <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!w_bit_end) begin
            r_clk_cnt <= r_clk_cnt + c_clk_w'(1);
          end else begin
            r_clk_cnt <= '0;
            if (r_bit_cnt != 5'd23) begin
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit     <= r_shift[22];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_trigger <= 1'b1;
            end else if ((r_pixel_index != c_led_count) && r_shadow_full) begin
              r_shift       <= r_shadow;
              r_bit         <= r_shadow[23];
              r_shadow_full <= 1'b0;
              r_pixel_index <= r_pixel_index + c_idx_w'(1);
              r_bit_cnt     <= '0;
              r_trigger     <= 1'b1;
            end else begin
              // Either the frame is complete or the source starved us.
              if (r_pixel_index != c_led_count) begin
                r_underrun <= 1'b1;
                r_aborted  <= 1'b1;
              end
              r_bit     <= 1'b0;
              r_gap_cnt <= '0;
              r_state   <= ST_LATCH;
            end
          end
        end

        ST_LATCH: begin
          if (r_gap_cnt == c_gap_last) begin
            r_frame_done <= !r_aborted;
            r_state      <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
